// File: rtl/dadd_share_pkg.sv
// dadd_share_pkg: shared types, constants and round-robin pick for the adder-sharing controller
package dadd_share_pkg;
  localparam int DATA_W = 64;
  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;
  // returns {valid, index}: first set bit of req at or after ptr, wrapping at n (n <= 8)
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [3:0] r;
    int k;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if (i < n && req[3'(k)]) r = {1'b1, 3'(k)};
    end
    return r;
  endfunction
endpackage

// File: rtl/dadd_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick with a pointer advanced past the last served requester
module rr_arbiter import dadd_share_pkg::*; #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             upd,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  logic [IDX_W-1:0] ptr;
  logic [3:0] pick;
  always_comb pick = rr_pick(8'(req), 3'(ptr), N_REQ);
  assign idx = IDX_W'(pick[2:0]);
  assign valid = pick[3];
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (upd) ptr <= (int'(last) == N_REQ - 1) ? '0 : last + 1'b1;
endmodule

// File: rtl/dadd_share_ctrl.sv
// dadd_share_ctrl: round-robin sharing of one double_adder among N_REQ requesters, one op in flight.
// Optional DADD_SHARE_STATS_EN adds saturating ops_done / busy_cycles counters.
module dadd_share_ctrl import dadd_share_pkg::*; #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ-1:0]        req_stb,
  output logic [N_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]       resp_z,
  output logic [N_REQ-1:0]        resp_stb,
  input  logic [N_REQ-1:0]        resp_ack,
  output logic [DATA_W-1:0]       add_a,
  output logic [DATA_W-1:0]       add_b,
  output logic                    add_a_stb,
  output logic                    add_b_stb,
  input  logic                    add_a_ack,
  input  logic                    add_b_ack,
  input  logic [DATA_W-1:0]       add_z,
  input  logic                    add_z_stb,
  output logic                    add_z_ack,
  output logic                    busy
`ifdef DADD_SHARE_STATS_EN
  ,
  output logic [31:0]             ops_done,
  output logic [31:0]             busy_cycles
`endif
);
  state_t state, state_n;
  logic [IDX_W-1:0] gnt, pick_idx;
  logic pick_valid, done;
  logic [DATA_W-1:0] op_a, op_b;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk(clk), .rst(rst), .req(req_stb), .upd(done), .last(gnt), .idx(pick_idx), .valid(pick_valid)
  );
  assign done = state == RESP && resp_ack[gnt];
  assign add_a = op_a;
  assign add_b = op_b;
  always_comb begin
    state_n = state;
    req_ack = '0;
    resp_stb = '0;
    add_a_stb = 1'b0;
    add_b_stb = 1'b0;
    add_z_ack = 1'b0;
    busy = state != IDLE;
    case (state)
      IDLE: begin
        state_n = pick_valid ? SEND_A : IDLE;
        if (pick_valid && !rst) req_ack[pick_idx] = 1'b1;
      end
      SEND_A: begin
        add_a_stb = 1'b1;
        state_n = add_a_ack ? SEND_B : SEND_A;
      end
      SEND_B: begin
        add_b_stb = 1'b1;
        state_n = add_b_ack ? WAIT_Z : SEND_B;
      end
      WAIT_Z: begin
        add_z_ack = 1'b1;
        state_n = add_z_stb ? RESP : WAIT_Z;
      end
      RESP: begin
        resp_stb[gnt] = 1'b1;
        state_n = resp_ack[gnt] ? IDLE : RESP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      op_a <= '0;
      op_b <= '0;
      resp_z <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && pick_valid) begin
        gnt <= pick_idx;
        op_a <= req_a[pick_idx*DATA_W +: DATA_W];
        op_b <= req_b[pick_idx*DATA_W +: DATA_W];
      end
      if (state == WAIT_Z && add_z_stb) resp_z <= add_z;
    end
`ifdef DADD_SHARE_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      ops_done <= '0;
      busy_cycles <= '0;
    end else begin
      if (done && ops_done != '1) ops_done <= ops_done + 1;
      if (busy && busy_cycles != '1) busy_cycles <= busy_cycles + 1;
    end
`endif
endmodule

// File: tb/tb_dadd_share_ctrl.sv
// tb_dadd_share_ctrl: randomized bench with a transaction-level reference model and a behavioural adder
module tb_dadd_share_ctrl;
  localparam int N = 4;
  logic clk = 0, rst = 1;
  logic [N*64-1:0] req_a = '0, req_b = '0;
  logic [N-1:0] req_stb = '0, req_ack, resp_stb, resp_ack = '0;
  logic [63:0] resp_z, add_a, add_b, add_z = '0;
  logic add_a_stb, add_b_stb, add_a_ack = 0, add_b_ack = 0, add_z_stb = 0, add_z_ack, busy;
`ifdef DADD_SHARE_STATS_EN
  logic [31:0] ops_done, busy_cycles;
`endif

  dadd_share_ctrl #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .resp_z(resp_z), .resp_stb(resp_stb), .resp_ack(resp_ack), .add_a(add_a), .add_b(add_b),
    .add_a_stb(add_a_stb), .add_b_stb(add_b_stb), .add_a_ack(add_a_ack), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack), .busy(busy)
`ifdef DADD_SHARE_STATS_EN
    , .ops_done(ops_done), .busy_cycles(busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd_dbl();
    return $realtobits(real'($urandom_range(0, 4000)) / 16.0 - 125.0);
  endfunction

  // behavioural adder: random/fixed ack delays, stray acks while computing, then result
  int dly = 0, ast = 0, cnt = 0, tgt = 0;
  bit dly_fix = 1;
  logic [63:0] xa, xb;
  function automatic int pickd();
    return dly_fix ? dly : int'($urandom_range(0, dly));
  endfunction
  initial forever begin
    @(posedge clk); #2;
    if (rst) begin
      add_a_ack = 0; add_b_ack = 0; add_z_stb = 0; ast = 0; cnt = 0; tgt = pickd();
    end else case (ast)
      0: if (add_a_stb) begin
        if (cnt >= tgt) begin add_a_ack = 1; xa = add_a; ast = 1; end else cnt++;
      end
      1: begin add_a_ack = 0; cnt = 0; tgt = pickd(); ast = 2; end
      2: if (add_b_stb) begin
        if (cnt >= tgt) begin add_b_ack = 1; xb = add_b; ast = 3; end else cnt++;
      end
      3: begin add_b_ack = 0; cnt = 0; tgt = pickd(); ast = 4; end
      4: begin
        add_a_ack = 1'($urandom_range(0, 1));
        add_b_ack = 1'($urandom_range(0, 1));
        if (cnt >= tgt && add_z_ack) begin
          add_z = $realtobits($bitstoreal(xa) + $bitstoreal(xb));
          add_z_stb = 1; add_a_ack = 0; add_b_ack = 0; ast = 5;
        end else cnt++;
      end
      default: begin add_z_stb = 0; cnt = 0; tgt = pickd(); ast = 0; end
    endcase
  end

  // reference model: one op in flight, round-robin grant, handshakes in a/b/z/resp order
  bit inf = 0;
  int cur = 0, mptr = 0, ph = 0, ops = 0, bc = 0, w;
  logic [63:0] ea, eb, ez;
  logic [N-1:0] exp_ack;
  int glog[$];
  always @(negedge clk) begin
    if (rst) begin
      inf = 0; mptr = 0; ph = 0; ops = 0; bc = 0;
    end else begin
      if (busy) bc++;
      exp_ack = '0;
      w = -1;
      chk("busy", busy, inf);
      if (!inf) begin
        for (int k = 0; k < N; k++) if (w < 0 && req_stb[(mptr + k) % N]) w = (mptr + k) % N;
        if (w >= 0) exp_ack[w] = 1'b1;
        chk("idle_outputs", {add_a_stb, add_b_stb, add_z_ack, resp_stb}, 0);
      end else begin
        chk("add_a_hold", add_a, ea);
        chk("add_b_hold", add_b, eb);
        chk("add_a_stb", add_a_stb, ph == 0);
        chk("add_b_stb", add_b_stb, ph == 1);
        chk("add_z_ack", add_z_ack, ph == 2);
        chk("resp_stb", resp_stb, ph == 3 ? (1 << cur) : 0);
        if (ph == 3) chk("resp_z", resp_z, ez);
        if (ph == 0 && add_a_stb && add_a_ack) ph = 1;
        else if (ph == 1 && add_b_stb && add_b_ack) ph = 2;
        else if (ph == 2 && add_z_ack && add_z_stb) ph = 3;
        else if (ph == 3 && resp_ack[cur]) begin inf = 0; mptr = (cur + 1) % N; ops++; end
      end
      chk("req_ack", req_ack, exp_ack);
      if (w >= 0) begin
        inf = 1; cur = w; ph = 0;
        ea = req_a[w*64 +: 64];
        eb = req_b[w*64 +: 64];
        ez = $realtobits($bitstoreal(ea) + $bitstoreal(eb));
        glog.push_back(w);
      end
    end
  end

  // stimulus: mode 0 manual, 1 random, 2 all continuously requesting, 3 drain
  int mode = 0;
  logic [N-1:0] acks, rsp;
  logic zk, ast_s, bst_s, bsy;
  logic [63:0] z_s, z;
  task automatic newop(input int i);
    req_a[i*64 +: 64] = rnd_dbl();
    req_b[i*64 +: 64] = rnd_dbl();
  endtask
  task automatic step();
    @(negedge clk);
    acks = req_ack; rsp = resp_stb; zk = add_z_ack; ast_s = add_a_stb; bst_s = add_b_stb;
    bsy = busy; z_s = resp_z;
    @(posedge clk); #1;
    if (mode != 0) for (int i = 0; i < N; i++) begin
      if (acks[i]) begin
        if (mode == 2) newop(i); else req_stb[i] = 0;
      end else if (mode == 1 && !req_stb[i] && $urandom_range(0, 3) == 0) begin
        newop(i); req_stb[i] = 1;
      end
    end
    if (mode == 1) resp_ack = N'($urandom); else if (mode >= 2) resp_ack = '1;
  endtask
  task automatic do_reset();
    rst = 1; repeat (3) step(); rst = 0; glog.delete();
  endtask
  task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b);
    bit ok = 0;
    req_a[i*64 +: 64] = a; req_b[i*64 +: 64] = b; req_stb[i] = 1;
    for (int k = 0; k < 100 && !ok; k++) begin step(); ok = acks[i]; end
    req_stb[i] = 0;
    chk("grant_wait", ok, 1);
  endtask
  task automatic get_resp(input int i, output logic [63:0] zz);
    bit ok = 0;
    zz = '0;
    for (int k = 0; k < 300 && !ok; k++) begin
      step();
      if (rsp[i]) begin ok = 1; zz = z_s; end
    end
    chk("resp_wait", ok, 1);
  endtask
  task automatic settle();
    bit ok = 0;
    mode = 3;
    for (int k = 0; k < 600 && !ok; k++) begin
      step();
      ok = !bsy && acks == 0 && req_stb == 0;
    end
    chk("drain", ok, 1);
    mode = 0;
  endtask

  int ga, aa;
  int exp_order[5] = '{0, 1, 2, 3, 0};
  initial begin
    do_reset();
    step();
    chk("rst_busy", bsy, 0);
    chk("rst_outputs", {acks, rsp, ast_s, bst_s, zk}, 0);
    chk("rst_resp_z", z_s, 0);
    resp_ack = '1;
    issue(0, 64'h3FF0000000000000, 64'h4000000000000000);
    step();
    chk("req_ack_one_cycle", acks, 0);
    get_resp(0, z);
    chk("sum_1_plus_2", z, 64'h4008000000000000);
    chk("single_grant", glog.size(), 1);

    for (int i = 0; i < N; i++) newop(i);
    req_stb = '1; mode = 2;
    do_reset();
    for (int k = 0; k < 200 && glog.size() < 5; k++) step();
    chk("rr_five_grants", glog.size() >= 5, 1);
    if (glog.size() >= 5) for (int k = 0; k < 5; k++) chk("rr_order", glog[k], exp_order[k]);
    settle();

    do_reset();
    resp_ack = '0;
    issue(2, $realtobits(2.5), $realtobits(0.5));
    get_resp(2, z);
    chk("sum_2p5_plus_0p5", z, 64'h4008000000000000);
    newop(1); req_stb[1] = 1; ga = 0; aa = 0;
    for (int k = 0; k < 10; k++) begin step(); ga += int'(acks[1]); aa += int'(ast_s); end
    chk("stall_no_ack", ga, 0);
    chk("stall_no_add_a_stb", aa, 0);
    resp_ack[2] = 1;
    step(); step();
    chk("grant_after_stall", acks[1], 1);
    req_stb[1] = 0; resp_ack = '1;
    get_resp(1, z);
    settle();

    dly = 5; dly_fix = 1;
    issue(3, rnd_dbl(), rnd_dbl());
    for (int k = 0; k < 100 && !zk; k++) step();
    chk("reach_wait_z", zk, 1);
    rst = 1; step(); rst = 0; step();
    chk("midrst_outputs", {acks, rsp, ast_s, bst_s, zk}, 0);
    chk("midrst_busy", bsy, 0);
    chk("midrst_resp_z", z_s, 0);
    issue(0, 64'h3FF0000000000000, 64'h3FF0000000000000);
    get_resp(0, z);
    chk("sum_1_plus_1", z, 64'h4000000000000000);

    dly = 0; dly_fix = 1; mode = 1;
    repeat (300) step();
    settle();
    dly = 5; resp_ack = '1;
    issue(1, $realtobits(1.5), $realtobits(2.25));
    get_resp(1, z);
    chk("sum_delay5", z, 64'h400E000000000000);
    mode = 1;
    repeat (300) step();
    settle();
    dly = 3; dly_fix = 0; mode = 1;
    repeat (400) step();
    settle();

`ifdef DADD_SHARE_STATS_EN
    dly = 2; dly_fix = 0; resp_ack = '1;
    do_reset();
    for (int k = 0; k < 6; k++) begin issue(k % N, rnd_dbl(), rnd_dbl()); get_resp(k % N, z); end
    step();
    chk("ops_done", ops_done, 6);
    chk("ops_model", ops, 6);
    chk("busy_cycles", busy_cycles, bc);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/dadd_share_ctrl.md
Name: dadd_share_ctrl

Overview:
- Round-robin controller that shares one double_adder instance among N_REQ requesters in the LU decomposition datapath.
- Accepts operand pairs from requesters and sequences the adder's a/b/z strobe-ack handshakes.
- Returns each sum to the requester that issued it; one operation in flight at a time.
- Sits between the LU update engines and the adder.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 64, operand/result width (IEEE-754 double; fixed by adder)
IDX_W, $clog2(N_REQ), requester index width (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_a  in  N_REQ*DATA_W  operand a per requester (slice i = requester i)
req_b  in  N_REQ*DATA_W  operand b per requester
req_stb  in  N_REQ  requester i has a valid operand pair
req_ack  out  N_REQ  one-cycle pulse: operands of requester i captured
resp_z  out  DATA_W  result, shared bus
resp_stb  out  N_REQ  result valid for requester i (one-hot or zero)
resp_ack  in  N_REQ  requester i consumes result
add_a  out  DATA_W  to adder input_a
add_b  out  DATA_W  to adder input_b
add_a_stb  out  1  to adder input_a_stb
add_b_stb  out  1  to adder input_b_stb
add_a_ack  in  1  from adder input_a_ack
add_b_ack  in  1  from adder input_b_ack
add_z  in  DATA_W  from adder output_z
add_z_stb  in  1  from adder output_z_stb
add_z_ack  out  1  to adder output_z_ack
busy  out  1  operation in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, req_ack=0, resp_stb=0, resp_z=0, add_*_stb=0, add_z_ack=0, busy=0, rr pointer=0 (requester 0 highest priority).
- Transfer rule on all adder channels: a word moves on a rising edge where stb && ack are both 1.
- FSM states and transitions:
  - IDLE: if any req_stb is set, grant the first set bit at or after ptr (wrapping). Capture req_a/req_b slices into op_a/op_b and the index into gnt. Pulse req_ack[gnt] for that one cycle. Go to SEND_A. Otherwise stay in IDLE.
  - SEND_A: add_a_stb=1, add_a=op_a. On add_a_ack, drop add_a_stb and go to SEND_B.
  - SEND_B: add_b_stb=1, add_b=op_b. On add_b_ack, drop add_b_stb and go to WAIT_Z.
  - WAIT_Z: add_z_ack=1. On add_z_stb, latch add_z into resp_z, drop add_z_ack and go to RESP.
  - RESP: resp_stb[gnt]=1 and resp_z held stable. On resp_ack[gnt], clear resp_stb, set ptr=gnt+1 (wrap at N_REQ) and go to IDLE.
- Latency: req_ack is asserted in the grant cycle T. add_a_stb is high from T+1. resp_stb rises on the edge after the z transfer. Controller overhead is 3 cycles beyond adder latency (grant, z capture, return-to-IDLE).
- Stable outputs: add_a/add_b hold op_a/op_b in all non-IDLE states.
- Requester rules: a requester holds req_stb and its operands until it sees req_ack. req_stb from an already granted requester is ignored until the FSM is back in IDLE.
- Back-pressure: while resp_ack stays low, the FSM remains in RESP. No new grant is made and the adder stays idle.
- Ignored inputs: resp_ack on a non-granted index and add_*_ack outside the matching state have no effect.
- Simultaneous requests: only one grant per IDLE cycle. Others wait. The fairness bound is N_REQ-1 operations.
- Reset mid-operation: all strobes and resp_stb are cleared on the next edge and any in-flight result is discarded. The adder shares rst, so both blocks restart cleanly.

Optional Feature:
- Macro DADD_SHARE_STATS_EN.
- With it:
  - Extra output ops_done[31:0]: increments on each resp_stb && resp_ack.
  - Extra output busy_cycles[31:0]: increments every cycle busy=1.
  - Both counters saturate at 0xFFFFFFFF and clear on rst.
- Without it: neither port nor counter logic exists.

Decomposition:
- Package dadd_share_pkg:
  - FSM state enum {IDLE, SEND_A, SEND_B, WAIT_Z, RESP}
  - DATA_W constant
  - function rr_pick(req, ptr) returning the winning index and a valid flag
- Sub-module rr_arbiter (N_REQ): combinational pick plus registered pointer, with an update strobe driven at RESP completion.

Test Plan:
- Single op: requester 0 sends a=0x3FF0000000000000, b=0x4000000000000000 -> resp_stb[0] with resp_z=0x4008000000000000; req_ack[0] is exactly one cycle.
- All four requesters assert req_stb continuously from reset -> grant order 0,1,2,3,0; each result reaches only its own resp_stb bit.
- Requester 2 holds resp_ack low for 10 cycles while requester 1 requests -> no req_ack[1] and no add_a_stb during the stall; requester 1 is granted the cycle after the ack.
- rst pulsed during WAIT_Z -> next cycle all stb/ack outputs are 0 and busy=0. A fresh op 1.0+1.0 then returns 0x4000000000000000.
- Adder with 0 and with 5 extra cycles of ack delay -> operands stay stable on add_a/add_b until transfer and results are unchanged.
- With DADD_SHARE_STATS_EN: 6 ops -> ops_done=6 and busy_cycles equals the measured busy-high count.
